// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  localparam int WORD_BYTES = 4;
  localparam int LAT_W      = 4;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;
  typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_BAD} dmem_op_t;

  // Word-index width; a single-word memory still needs a one-bit index.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 single-port storage: byte-enabled synchronous write, registered read.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int IDX_W = idx_width(DEPTH)
) (
  input  logic                  clk,
  input  logic [IDX_W-1:0]      index,
  input  logic                  re,
  input  logic                  we,
  input  logic [WORD_BYTES-1:0] be,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [DEPTH];

  // NOTE: storage has no reset branch; contents survive reset and map onto RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < WORD_BYTES; i++) begin
        if (be[i]) mem[index][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata <= mem[index];
  end

endmodule

// File: rtl/dmem_responder.sv
// Load/store port responder: one request at a time, completed after LATENCY
// cycles with a one-cycle Ready pulse, qualified by Error on rejected requests.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] DataAdr,
  input  logic [31:0] WriteData,
  input  logic [3:0]  ByteEn,
  output logic [31:0] ReadData,
  output logic        Ready,
  output logic        Busy,
  output logic        Error
);

  localparam int IDX_W = idx_width(DEPTH);

  dmem_state_t      state, state_nx;
  logic [LAT_W-1:0] cnt;
  dmem_op_t         op_q;
  logic [31:0]      adr_q, wdata_q;
  logic [3:0]       be_q;
  logic             accept, done, bad, rd_valid;
  logic             mem_re, mem_we;
  logic [31:0]      mem_rdata;
  logic [IDX_W-1:0] idx;

  // Rejection is decided on the latched request so it is stable through RESP.
  assign bad = (op_q == OP_BAD) || (adr_q[1:0] != 2'b00) ||
               ({2'b00, adr_q[31:2]} >= 32'(DEPTH));
  assign idx = adr_q[IDX_W+1:2];

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // NOTE: default to holding state so every path assigns state_nx (no latch).
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (MemRead || MemWrite) state_nx = WAIT;
      WAIT:    if (cnt == '0)           state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    Busy     = (state != IDLE);
    Ready    = (state == RESP);
    Error    = Ready && bad;
    accept   = (state == IDLE) && (MemRead || MemWrite);
    done     = (state == WAIT) && (cnt == '0);
    mem_we   = reset && done && (op_q == OP_WRITE) && !bad;
    mem_re   = reset && done && (op_q == OP_READ)  && !bad;
    ReadData = rd_valid ? mem_rdata : '0;
  end

  // Request latch and wait counter; only meaningful outside IDLE.
  always_ff @(posedge clk) begin
    if (accept) begin
      adr_q   <= DataAdr;
      wdata_q <= WriteData;
      be_q    <= ByteEn;
      op_q    <= (MemRead && MemWrite) ? OP_BAD : (MemWrite ? OP_WRITE : OP_READ);
      cnt     <= LAT_W'(LATENCY - 1);
    end else if ((state == WAIT) && (cnt != '0)) begin
      cnt <= cnt - LAT_W'(1);
    end
  end

  // Read data stays visible until a later read or a rejection replaces it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_valid <= 1'b0;
    end else if (done) begin
      if (bad)                  rd_valid <= 1'b0;
      else if (op_q == OP_READ) rd_valid <= 1'b1;
    end
  end

  dmem_array #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_array (
    .clk   (clk),
    .index (idx),
    .re    (mem_re),
    .we    (mem_we),
    .be    (be_q),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a scoreboard queue checked by a
// monitor on every Ready pulse (latency, Error and ReadData).
module tb_dmem_responder;

  localparam int DEPTH   = 64;
  localparam int LATENCY = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [31:0] DataAdr, WriteData;
  logic [3:0]  ByteEn;
  logic [31:0] ReadData;
  logic        Ready, Busy, Error;

  typedef struct {
    logic        err;
    logic [31:0] rd;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cycle = 0;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .DataAdr   (DataAdr),
    .WriteData (WriteData),
    .ByteEn    (ByteEn),
    .ReadData  (ReadData),
    .Ready     (Ready),
    .Busy      (Busy),
    .Error     (Error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, req, cycle);
    end
  endtask

  // Monitor: every Ready cycle must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (Ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_ready: got Ready=1, want no completion (cycle %0d)", cycle);
      end else begin
        mon_e = sb_q.pop_front();
        check("ready_cycle", 32'(cycle), 32'(mon_e.cyc));
        check("error", {31'd0, Error}, {31'd0, mon_e.err});
        check("read_data", ReadData, mon_e.rd);
      end
    end
  end

  task automatic wait_ready(input string name);
    int n = 0;
    while (Ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (Ready !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got no Ready in 20 cycles, want Ready", name);
    end
    @(negedge clk);
  endtask

  task automatic do_req(input string name, input logic rd, input logic wr,
                        input logic [31:0] adr, input logic [31:0] wd,
                        input logic [3:0] be, input logic exp_err,
                        input logic [31:0] exp_rd);
    @(negedge clk);
    check({name, "_idle"}, {31'd0, Busy}, 32'd0);
    MemRead   = rd;
    MemWrite  = wr;
    DataAdr   = adr;
    WriteData = wd;
    ByteEn    = be;
    sb_q.push_back('{err: exp_err, rd: exp_rd, cyc: cycle + 1 + LATENCY});
    @(negedge clk);
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    check({name, "_busy"}, {31'd0, Busy}, 32'd1);
    wait_ready(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    DataAdr   = '0;
    WriteData = '0;
    ByteEn    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready",     {31'd0, Ready}, 32'd0);
    check("rst_busy",      {31'd0, Busy},  32'd0);
    check("rst_error",     {31'd0, Error}, 32'd0);
    check("rst_read_data", ReadData,       32'd0);
    reset = 1'b1;

    // Basic write/read, byte-lane merge, zero-enable write, last valid word
    do_req("wr100",    0, 1, 32'd100, 32'h0000_0007, 4'hF, 0, 32'h0);
    do_req("rd100",    1, 0, 32'd100, 32'h0,         4'hF, 0, 32'h7);
    do_req("wr96",     0, 1, 32'd96,  32'hAABB_CCDD, 4'hF, 0, 32'h7);
    do_req("wr96_be5", 0, 1, 32'd96,  32'h1122_3344, 4'h5, 0, 32'h7);
    do_req("rd96",     1, 0, 32'd96,  32'h0,         4'hF, 0, 32'hAA22_CC44);
    do_req("wr_be0",   0, 1, 32'd100, 32'hFFFF_FFFF, 4'h0, 0, 32'hAA22_CC44);

    // Rejected requests keep timing, raise Error, zero ReadData
    do_req("rd_mis",   1, 0, 32'd102, 32'h0,         4'hF, 1, 32'h0);
    do_req("rd_oor",   1, 0, 32'd256, 32'h0,         4'hF, 1, 32'h0);
    do_req("wr252",    0, 1, 32'd252, 32'h5A5A_0001, 4'hF, 0, 32'h0);
    do_req("rd252",    1, 0, 32'd252, 32'h0,         4'hF, 0, 32'h5A5A_0001);
    do_req("rw_both",  1, 1, 32'd96,  32'h0BAD_0BAD, 4'hF, 1, 32'h0);
    do_req("rd96_b",   1, 0, 32'd96,  32'h0,         4'hF, 0, 32'hAA22_CC44);
    do_req("rd100_b",  1, 0, 32'd100, 32'h0,         4'hF, 0, 32'h7);

    // A write held high while busy and across the RESP exit edge is ignored
    @(negedge clk);
    MemRead = 1'b1;
    DataAdr = 32'd100;
    ByteEn  = 4'hF;
    sb_q.push_back('{err: 1'b0, rd: 32'h7, cyc: cycle + 1 + LATENCY});
    @(negedge clk);
    MemRead   = 1'b0;
    MemWrite  = 1'b1;
    DataAdr   = 32'd96;
    WriteData = 32'hDEAD_BEEF;
    check("busy_hold_busy", {31'd0, Busy}, 32'd1);
    wait_ready("busy_hold");
    check("no_accept_on_exit", {31'd0, Busy}, 32'd0);
    MemWrite = 1'b0;
    do_req("rd96_c",   1, 0, 32'd96,  32'h0,         4'hF, 0, 32'hAA22_CC44);

    // Reset during a write aborts it: no Ready, memory keeps the old word
    @(negedge clk);
    MemWrite  = 1'b1;
    DataAdr   = 32'd100;
    WriteData = 32'h0000_0009;
    ByteEn    = 4'hF;
    @(negedge clk);
    MemWrite = 1'b0;
    check("abort_busy_before", {31'd0, Busy}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check("abort_busy_after", {31'd0, Busy}, 32'd0);
    check("abort_read_data",  ReadData,      32'd0);
    repeat (5) @(negedge clk);
    check("abort_still_idle", {31'd0, Busy}, 32'd0);
    do_req("rd100_c",  1, 0, 32'd100, 32'h0,         4'hF, 0, 32'h7);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
